sram_bus_bridge: RTL and testbench

Parametrised bridge between the PXA static-memory bus (SRAM-style, async nCS/nWE/nOE) and an internal true-dual-port block RAM window, with byte-lane writes, a doorbell interrupt register and a write counter. Host side is port A; a synchronous fabric port B lets user logic share the same memory. Sits at the FPGA top level, directly on the CPU data/address pins, replacing the fixed 16-bit single-RAM bus slave.

---
 rtl/sram_bus_bridge_pkg.sv | 18 +
 rtl/sram_bus_dpram.sv | 49 ++++
 rtl/sram_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_sram_bus_bridge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_bridge_pkg.sv
// Shared definitions for the SRAM bus bridge: byte-lane math and write FSM encoding.
// No logic, no latency.
// No flow control.
package sram_bus_bridge_pkg;

  // Host write sequencer states; WAIT_IDLE blocks commits until the strobe is seen released
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    WRITE     = 2'd2
  } wr_state_e;

  // Number of byte lanes on a data bus of the given width
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_bus_dpram.sv
// True-dual-port RAM: port A per-byte write enables, port B full-word writes.
// Latency: both read ports registered, 1 clk.
// No backpressure; on a same-address double write port A lands last and wins.
module sram_bus_dpram
  import sram_bus_bridge_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LANES  = lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [LANES-1:0]  a_be_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_we_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Array writes: port B whole word first, then port A byte lanes so A overrides on collision
  always_ff @(posedge clk) begin
    if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    for (int l = 0; l < LANES; l++) begin
      if (a_be_i[l]) mem_q[a_addr_i][l*8 +: 8] <= a_wdata_i[l*8 +: 8];
    end
  end

  // Registered reads on both ports, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem_q[a_addr_i];
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sram_bus_bridge.sv
// PXA static-memory bus slave onto a dual-port RAM window with doorbell irq and write counter.
// Latency: host commit SYNC_STAGES+1 clk after strobe release; host read data within SYNC_STAGES+2 clk.
// No backpressure: host relies on wait states; fabric write dropped when it collides with a host commit.
module sram_bus_bridge
  import sram_bus_bridge_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int DOORBELL_ADDR = 2**ADDR_W - 1,
  parameter int COUNT_ADDR    = 2**ADDR_W - 2,
  parameter int LED_BIT       = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_W-1:0]     sram_data,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  ncs,
  input  logic                  nwe,
  input  logic                  noe,
  input  logic [DATA_W/8-1:0]   nbe,
  input  logic [ADDR_W-1:0]     u_addr,
  input  logic                  u_we,
  input  logic [DATA_W-1:0]     u_wdata,
  output logic [DATA_W-1:0]     u_rdata,
  input  logic                  irq_ack,
  output logic                  irq,
  output logic                  led
);

  localparam int                LANES = lanes(DATA_W);
  localparam logic [ADDR_W-1:0] DB_A  = ADDR_W'(DOORBELL_ADDR);
  localparam logic [ADDR_W-1:0] CNT_A = ADDR_W'(COUNT_ADDR);

  logic [SYNC_STAGES-1:0] ncs_sync_q, nwe_sync_q, noe_sync_q;
  logic                   wr_act, rd_act, rd_act_q;
  logic [ADDR_W-1:0]      cap_addr_q, rd_addr_q, rd_sel_q;
  logic [DATA_W-1:0]      cap_data_q, doorbell_q, wr_cnt_q;
  logic [LANES-1:0]       cap_nbe_q;
  wr_state_e              state_q;
  logic                   commit, commit_db, commit_ram, irq_clr, irq_q;
  logic [LED_BIT:0]       hb_q;
  logic [DATA_W-1:0]      a_rdata, rd_data;
  logic [ADDR_W-1:0]      a_addr;
  logic [LANES-1:0]       a_be;
  logic                   b_we;

  // Strobe synchronisers; left out of reset so a strobe held through reset stays visible afterwards
  always_ff @(posedge clk) begin
    ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    nwe_sync_q <= {nwe_sync_q[SYNC_STAGES-2:0], nwe};
    noe_sync_q <= {noe_sync_q[SYNC_STAGES-2:0], noe};
  end

  assign wr_act = ~ncs_sync_q[SYNC_STAGES-1] & ~nwe_sync_q[SYNC_STAGES-1];
  assign rd_act = ~ncs_sync_q[SYNC_STAGES-1] & ~noe_sync_q[SYNC_STAGES-1] & nwe_sync_q[SYNC_STAGES-1];

  // Capture host address/data/lanes while a write is active; read address tracked every clk
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_nbe_q  <= '1;
      rd_addr_q  <= '0;
      rd_sel_q   <= '0;
    end else begin
      if (wr_act) begin
        cap_addr_q <= addr;
        cap_data_q <= sram_data;
        cap_nbe_q  <= nbe;
      end
      rd_addr_q <= addr;
      rd_sel_q  <= rd_addr_q;
    end
  end

  // Write sequencer: commit fires on the synchronised release of an active write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
    end else begin
      case (state_q)
        WAIT_IDLE: if (!wr_act) state_q <= IDLE;
        IDLE:      if (wr_act)  state_q <= WRITE;
        WRITE:     if (!wr_act) state_q <= IDLE;
        default:   state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign commit     = (state_q == WRITE) && !wr_act;
  assign commit_db  = commit && (cap_addr_q == DB_A);
  assign commit_ram = commit && (cap_addr_q != DB_A) && (cap_addr_q != CNT_A);
  assign irq_clr    = (rd_act_q && !rd_act && (rd_addr_q == DB_A)) || irq_ack;

  // Doorbell register, write counter and sticky irq (a set beats a simultaneous clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      doorbell_q <= '0;
      wr_cnt_q   <= '0;
      rd_act_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (commit_db) begin
        for (int l = 0; l < LANES; l++) begin
          if (!cap_nbe_q[l]) doorbell_q[l*8 +: 8] <= cap_data_q[l*8 +: 8];
        end
      end
      if (commit_db || commit_ram) wr_cnt_q <= wr_cnt_q + DATA_W'(1);
      rd_act_q <= rd_act;
      if (commit_db)    irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  // Free-running heartbeat
  always_ff @(posedge clk) begin
    if (reset) hb_q <= '0;
    else       hb_q <= hb_q + 1'b1;
  end

  // Port A serves the commit in its cycle, otherwise the registered read address
  assign a_addr = commit ? cap_addr_q : rd_addr_q;
  assign a_be   = commit_ram ? ~cap_nbe_q : '0;
  assign b_we   = u_we && !(commit_ram && (cap_addr_q == u_addr));

  sram_bus_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_addr_i  (a_addr),
    .a_be_i    (a_be),
    .a_wdata_i (cap_data_q),
    .a_rdata_o (a_rdata),
    .b_addr_i  (u_addr),
    .b_we_i    (b_we),
    .b_wdata_i (u_wdata),
    .b_rdata_o (u_rdata)
  );

  // Host read mux, aligned with the RAM's registered output
  always_comb begin
    rd_data = a_rdata;
    if (rd_sel_q == DB_A)       rd_data = doorbell_q;
    else if (rd_sel_q == CNT_A) rd_data = wr_cnt_q;
  end

  assign sram_data = (!ncs && !noe && nwe) ? rd_data : {DATA_W{1'bz}};
  assign irq       = irq_q;
  assign led       = hb_q[LED_BIT];

endmodule

// File: tb/tb_sram_bus_bridge.sv
module tb_sram_bus_bridge;

  localparam logic [9:0] DB  = 10'h3FF;
  localparam logic [9:0] CNT = 10'h3FE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  addr = '0;
  logic        ncs = 1'b1, nwe = 1'b1, noe = 1'b1;
  logic [1:0]  nbe = 2'b11;
  logic [9:0]  u_addr = '0;
  logic        u_we = 1'b0;
  logic [15:0] u_wdata = '0;
  logic [15:0] u_rdata;
  logic        irq_ack = 1'b0;
  logic        irq, led;
  logic        drv_en = 1'b0;
  logic [15:0] drv_dat = '0;
  wire  [15:0] sram_data;
  assign sram_data = drv_en ? drv_dat : 16'hzzzz;

  // small-width instance so the counter wrap fits in a short run
  logic [3:0]  addr2 = '0;
  logic        ncs2 = 1'b1, nwe2 = 1'b1, noe2 = 1'b1;
  logic [0:0]  nbe2 = 1'b0;
  logic [7:0]  u_rdata2;
  logic        irq2, led2;
  logic        drv2_en = 1'b0;
  logic [7:0]  drv2_dat = 8'h5A;
  wire  [7:0]  sram_data2;
  assign sram_data2 = drv2_en ? drv2_dat : 8'hzz;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  sram_bus_bridge dut (
    .clk(clk), .reset(reset), .sram_data(sram_data), .addr(addr),
    .ncs(ncs), .nwe(nwe), .noe(noe), .nbe(nbe),
    .u_addr(u_addr), .u_we(u_we), .u_wdata(u_wdata), .u_rdata(u_rdata),
    .irq_ack(irq_ack), .irq(irq), .led(led)
  );

  sram_bus_bridge #(.DATA_W(8), .ADDR_W(4), .LED_BIT(3)) dut8 (
    .clk(clk), .reset(reset), .sram_data(sram_data2), .addr(addr2),
    .ncs(ncs2), .nwe(nwe2), .noe(noe2), .nbe(nbe2),
    .u_addr(4'd0), .u_we(1'b0), .u_wdata(8'd0), .u_rdata(u_rdata2),
    .irq_ack(1'b0), .irq(irq2), .led(led2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // side: 0 none, 1 irq_ack in the commit cycle, 2 fabric write 0x2222 to the same address in the commit cycle
  task automatic host_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be_n, input int side);
    @(negedge clk);
    addr = a; drv_dat = d; drv_en = 1'b1; nbe = be_n; ncs = 1'b0; nwe = 1'b0;
    repeat (3) @(negedge clk);
    ncs = 1'b1; nwe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (side == 1) irq_ack = 1'b1;
    if (side == 2) begin u_addr = a; u_wdata = 16'h2222; u_we = 1'b1; end
    @(negedge clk);
    irq_ack = 1'b0; u_we = 1'b0;
    repeat (2) @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic host_read(input logic [9:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; ncs = 1'b0; noe = 1'b0;
    repeat (4) @(negedge clk);
    d = sram_data;
    ncs = 1'b1; noe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic fab_read(input logic [9:0] a, output logic [15:0] d);
    @(negedge clk);
    u_addr = a;
    @(negedge clk);
    d = u_rdata;
  endtask

  task automatic fab_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    u_addr = a; u_wdata = d; u_we = 1'b1;
    @(negedge clk);
    u_we = 1'b0;
  endtask

  task automatic write8;
    @(negedge clk);
    addr2 = 4'd15; drv2_en = 1'b1; ncs2 = 1'b0; nwe2 = 1'b0;
    repeat (3) @(negedge clk);
    ncs2 = 1'b1; nwe2 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_u_rdata", u_rdata, 16'h0);
    chk("rst_led", 16'(led), 16'h0);
    host_read(CNT, rd);      chk("rst_count", rd, 16'h0000);
    host_read(DB, rd);       chk("rst_doorbell", rd, 16'h0000);

    host_write(10'h010, 16'hA5C3, 2'b00, 0);
    fab_read(10'h010, rd);   chk("wr_full", rd, 16'hA5C3);
    host_read(CNT, rd);      chk("count_1", rd, 16'h0001);
    host_read(10'h010, rd);  chk("host_rd_ram", rd, 16'hA5C3);

    host_write(10'h010, 16'hFFFF, 2'b10, 0);
    fab_read(10'h010, rd);   chk("wr_lane0", rd, 16'hA5FF);

    host_write(DB, 16'h0001, 2'b00, 0);
    chk("db_irq_set", 16'(irq), 16'h1);
    host_read(DB, rd);       chk("db_read", rd, 16'h0001);
    chk("db_irq_clr_rd", 16'(irq), 16'h0);
    host_write(DB, 16'h0002, 2'b00, 1);
    chk("db_set_wins", 16'(irq), 16'h1);
    host_read(CNT, rd);      chk("count_4", rd, 16'h0004);
    @(negedge clk); irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    chk("irq_ack_clr", 16'(irq), 16'h0);

    host_write(CNT, 16'h00AA, 2'b00, 0);
    host_read(CNT, rd);      chk("count_ro", rd, 16'h0004);

    fab_write(10'h030, 16'h1234);
    @(negedge clk);
    addr = 10'h030; drv_dat = 16'hBEEF; drv_en = 1'b1; nbe = 2'b00; ncs = 1'b0; nwe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ncs = 1'b1; nwe = 1'b1;
    repeat (6) @(negedge clk);
    drv_en = 1'b0;
    fab_read(10'h030, rd);   chk("rstmid_ram", rd, 16'h1234);
    host_read(CNT, rd);      chk("rstmid_count", rd, 16'h0000);
    host_write(10'h030, 16'h5678, 2'b00, 0);
    fab_read(10'h030, rd);   chk("rstmid_next", rd, 16'h5678);
    host_read(CNT, rd);      chk("rstmid_cnt1", rd, 16'h0001);

    host_write(10'h020, 16'h1111, 2'b00, 2);
    fab_read(10'h020, rd);   chk("collide_host", rd, 16'h1111);
    fab_write(10'h021, 16'h2222);
    fab_read(10'h021, rd);   chk("fab_write", rd, 16'h2222);

    for (int i = 0; i < 255; i++) write8();
    @(negedge clk);
    drv2_en = 1'b0; addr2 = 4'd14; ncs2 = 1'b0; noe2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt8_ff", 16'(sram_data2), 16'h00FF);
    ncs2 = 1'b1; noe2 = 1'b1;
    repeat (4) @(negedge clk);
    write8();
    @(negedge clk);
    drv2_en = 1'b0; addr2 = 4'd14; ncs2 = 1'b0; noe2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt8_wrap", 16'(sram_data2), 16'h0000);
    ncs2 = 1'b1; noe2 = 1'b1;
    chk("irq8_set", 16'(irq2), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
